// File: rtl/tcp_vlg_ack_sched_if.sv
// Connection-side signal bundle for the pure-Ack scheduler: rx segment events in,
// Ack request/handshake to the tx engine.
interface tcp_vlg_ack_sched_if #(
   parameter int LEN_W = 16
);
   logic             connected;
   logic             init;
   logic             seg_val;
   logic [LEN_W-1:0] seg_len;
   logic             seg_in_order;
   logic             sack_upd;
   logic [31:0]      loc_ack;
   logic [LEN_W-1:0] win;
   logic             send;
   logic [2:0]       reason;
   logic [31:0]      ack_num;
   logic             sent;

   modport master (
      output connected, init, seg_val, seg_len, seg_in_order, sack_upd,
      output loc_ack, win, sent,
      input  send, reason, ack_num
   );

   modport slave (
      input  connected, init, seg_val, seg_len, seg_in_order, sack_upd,
      input  loc_ack, win, sent,
      output send, reason, ack_num
   );
endinterface

// File: rtl/tcp_vlg_ack_sched.sv
// Per-connection pure-Ack scheduler: collects Ack triggers from the rx path and
// holds a single Ack request towards the tx engine until it reports the Ack sent.
module tcp_vlg_ack_sched #(
   parameter int ACK_TIMEOUT       = 20,
   parameter int FORCE_ACK_PACKETS = 5,
   parameter int FORCE_ACK_BYTES   = 2920,
   parameter int DUP_ACK_LIMIT     = 3,
   parameter int WIN_UPD_THRESH    = 1460,
   parameter int LEN_W             = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   tcp_vlg_ack_sched_if.slave    ack_if
);

   localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
   localparam int DUP_W = (DUP_ACK_LIMIT > 0) ? $clog2(DUP_ACK_LIMIT + 1) : 1;

   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
   localparam logic [DUP_W-1:0] DUP_LIM  = DUP_W'(DUP_ACK_LIMIT);
   localparam logic [15:0]      PKT_LIM  = 16'(FORCE_ACK_PACKETS);
   localparam logic [31:0]      BYTE_LIM = 32'(FORCE_ACK_BYTES);
   localparam logic [LEN_W-1:0] WIN_TH   = LEN_W'(WIN_UPD_THRESH);

   localparam logic [2:0] RSN_TMO  = 3'd0;
   localparam logic [2:0] RSN_PKTS = 3'd1;
   localparam logic [2:0] RSN_BYTE = 3'd2;
   localparam logic [2:0] RSN_DUP  = 3'd3;
   localparam logic [2:0] RSN_SACK = 3'd4;
   localparam logic [2:0] RSN_WIN  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PEND = 2'd1,
      ST_REQ  = 2'd2
   } state_t;

   state_t             state_q,    state_d;
   logic [15:0]        pkt_cnt_q,  pkt_cnt_d;
   logic [31:0]        byte_cnt_q, byte_cnt_d;
   logic [TMR_W-1:0]   timer_q,    timer_d;
   logic [DUP_W-1:0]   dup_cnt_q,  dup_cnt_d;
   logic [LEN_W-1:0]   last_win_q, last_win_d;
   logic               send_q,     send_d;
   logic [2:0]         reason_q,   reason_d;
   logic [31:0]        ack_num_q,  ack_num_d;

   logic               hold_clr;
   logic               in_pay;
   logic               ooo;
   logic               dup_ok;
   logic [31:0]        seg_len_ext;
   logic [32:0]        byte_sum;
   logic [15:0]        pkt_upd;
   logic [31:0]        byte_upd;
   logic               trig_dup;
   logic               trig_sack;
   logic               trig_bytes;
   logic               trig_pkts;
   logic               trig_win;
   logic               trig_tmo;
   logic               any_trig;
   logic [2:0]         reason_sel;

   assign hold_clr    = ack_if.init | ~ack_if.connected;
   assign in_pay      = ack_if.seg_val & ack_if.seg_in_order & (ack_if.seg_len != '0);
   assign ooo         = ack_if.seg_val & ~ack_if.seg_in_order;
   assign dup_ok      = ooo & (dup_cnt_q < DUP_LIM);

   // Counters saturate rather than wrap so a stalled tx engine cannot hide a trigger.
   assign seg_len_ext = 32'(ack_if.seg_len);
   assign byte_sum    = {1'b0, byte_cnt_q} + {1'b0, seg_len_ext};
   assign byte_upd    = !in_pay ? byte_cnt_q : (byte_sum[32] ? 32'hFFFF_FFFF : byte_sum[31:0]);
   assign pkt_upd     = (in_pay && pkt_cnt_q != 16'hFFFF) ? pkt_cnt_q + 16'd1 : pkt_cnt_q;

   assign trig_dup    = dup_ok;
   assign trig_sack   = ack_if.sack_upd;
   assign trig_bytes  = (BYTE_LIM != 32'd0) && (byte_upd >= BYTE_LIM);
   assign trig_pkts   = (PKT_LIM != 16'd0) && (pkt_upd >= PKT_LIM);
   assign trig_win    = (ack_if.win > last_win_q) && ((ack_if.win - last_win_q) >= WIN_TH);
   assign trig_tmo    = (state_q == ST_PEND) && (timer_q == TMR_LAST);
   assign any_trig    = trig_dup | trig_sack | trig_bytes | trig_pkts | trig_win | trig_tmo;

   always_comb begin
      reason_sel = RSN_TMO;
      if (trig_dup)        reason_sel = RSN_DUP;
      else if (trig_sack)  reason_sel = RSN_SACK;
      else if (trig_bytes) reason_sel = RSN_BYTE;
      else if (trig_pkts)  reason_sel = RSN_PKTS;
      else if (trig_win)   reason_sel = RSN_WIN;
   end

   always_comb begin
      state_d    = state_q;
      pkt_cnt_d  = pkt_cnt_q;
      byte_cnt_d = byte_cnt_q;
      timer_d    = timer_q;
      dup_cnt_d  = dup_cnt_q;
      last_win_d = last_win_q;
      send_d     = send_q;
      reason_d   = reason_q;
      ack_num_d  = ack_num_q;

      // Duplicate-Ack budget is per out-of-order run and counts even while a request is open.
      if (dup_ok) begin
         dup_cnt_d = dup_cnt_q + DUP_W'(1);
      end else if (in_pay) begin
         dup_cnt_d = '0;
      end

      case (state_q)
         ST_IDLE, ST_PEND: begin
            pkt_cnt_d  = pkt_upd;
            byte_cnt_d = byte_upd;
            if (state_q == ST_PEND) begin
               timer_d = timer_q + TMR_W'(1);
            end else if (in_pay) begin
               timer_d = '0;
            end
            if (any_trig) begin
               state_d   = ST_REQ;
               send_d    = 1'b1;
               reason_d  = reason_sel;
               ack_num_d = ack_if.loc_ack;
            end else if (in_pay) begin
               state_d = ST_PEND;
            end
         end
         ST_REQ: begin
            pkt_cnt_d  = pkt_upd;
            byte_cnt_d = byte_upd;
            if (ack_if.sent) begin
               send_d     = 1'b0;
               last_win_d = ack_if.win;
               timer_d    = '0;
               // A segment landing with the sent pulse is not covered by that Ack.
               if (in_pay) begin
                  pkt_cnt_d  = 16'd1;
                  byte_cnt_d = seg_len_ext;
                  state_d    = ST_PEND;
               end else begin
                  pkt_cnt_d  = '0;
                  byte_cnt_d = '0;
                  state_d    = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (hold_clr) begin
         state_d    = ST_IDLE;
         pkt_cnt_d  = '0;
         byte_cnt_d = '0;
         timer_d    = '0;
         dup_cnt_d  = '0;
         last_win_d = ack_if.win;
         send_d     = 1'b0;
         reason_d   = RSN_TMO;
         ack_num_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pkt_cnt_q  <= '0;
         byte_cnt_q <= '0;
         timer_q    <= '0;
         dup_cnt_q  <= '0;
         last_win_q <= ack_if.win;
         send_q     <= 1'b0;
         reason_q   <= RSN_TMO;
         ack_num_q  <= '0;
      end else begin
         state_q    <= state_d;
         pkt_cnt_q  <= pkt_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         timer_q    <= timer_d;
         dup_cnt_q  <= dup_cnt_d;
         last_win_q <= last_win_d;
         send_q     <= send_d;
         reason_q   <= reason_d;
         ack_num_q  <= ack_num_d;
      end
   end

   assign ack_if.send    = send_q;
   assign ack_if.reason  = reason_q;
   assign ack_if.ack_num = ack_num_q;

endmodule

// File: tb/tb_tcp_vlg_ack_sched.sv
// Bench for tcp_vlg_ack_sched: directed scenarios plus a randomized run checked
// cycle by cycle against a trigger-rule reference model.
module tb_tcp_vlg_ack_sched;

   localparam int ACK_TIMEOUT = 20;
   localparam int FORCE_PKTS  = 5;
   localparam int FORCE_BYTES = 2920;
   localparam int DUP_LIMIT   = 3;
   localparam int WIN_THRESH  = 1460;
   localparam int LEN_W       = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tcp_vlg_ack_sched_if #(.LEN_W(LEN_W)) ifc();

   tcp_vlg_ack_sched #(
      .ACK_TIMEOUT      (ACK_TIMEOUT),
      .FORCE_ACK_PACKETS(FORCE_PKTS),
      .FORCE_ACK_BYTES  (FORCE_BYTES),
      .DUP_ACK_LIMIT    (DUP_LIMIT),
      .WIN_UPD_THRESH   (WIN_THRESH),
      .LEN_W            (LEN_W)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .ack_if(ifc)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: counts of unacked traffic and an outstanding-request flag.
   bit          m_req;
   bit          m_pend;
   int          m_pkts;
   longint      m_bytes;
   int          m_age;
   int          m_dup;
   int          m_last_win;
   int          m_reason;
   logic [31:0] m_ack;

   task automatic model_step();
      bit payload, ooo, dup_fire;
      int len, w, r;
      len = int'(ifc.seg_len);
      w   = int'(ifc.win);
      if (rst || ifc.init || !ifc.connected) begin
         m_req = 0; m_pend = 0; m_pkts = 0; m_bytes = 0; m_age = 0; m_dup = 0;
         m_last_win = w; m_reason = 0; m_ack = 32'd0;
         return;
      end
      payload  = ifc.seg_val && ifc.seg_in_order && (len > 0);
      ooo      = ifc.seg_val && !ifc.seg_in_order;
      dup_fire = ooo && (m_dup < DUP_LIMIT);
      if (dup_fire) m_dup++;
      else if (payload) m_dup = 0;
      if (m_req) begin
         if (ifc.sent) begin
            m_req = 0;
            m_last_win = w;
            if (payload) begin
               m_pkts = 1; m_bytes = len; m_pend = 1; m_age = 0;
            end else begin
               m_pkts = 0; m_bytes = 0; m_pend = 0;
            end
         end else if (payload) begin
            m_pkts  = (m_pkts + 1 > 65535) ? 65535 : m_pkts + 1;
            m_bytes = (m_bytes + len > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_bytes + len;
         end
         return;
      end
      if (payload) begin
         m_pkts  = (m_pkts + 1 > 65535) ? 65535 : m_pkts + 1;
         m_bytes = (m_bytes + len > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_bytes + len;
      end
      r = -1;
      if (dup_fire)                                     r = 3;
      else if (ifc.sack_upd)                            r = 4;
      else if (m_bytes >= FORCE_BYTES)                  r = 2;
      else if (m_pkts >= FORCE_PKTS)                    r = 1;
      else if (w > m_last_win && w - m_last_win >= WIN_THRESH) r = 5;
      else if (m_pend && m_age == ACK_TIMEOUT - 1)      r = 0;
      if (r >= 0) begin
         m_req = 1; m_reason = r; m_ack = ifc.loc_ack; m_pend = 0;
      end else if (m_pend) begin
         m_age++;
      end else if (payload) begin
         m_pend = 1; m_age = 0;
      end
   endtask

   task automatic clear_pulses();
      ifc.seg_val      = 1'b0;
      ifc.seg_len      = '0;
      ifc.seg_in_order = 1'b1;
      ifc.sack_upd     = 1'b0;
      ifc.sent         = 1'b0;
      ifc.init         = 1'b0;
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic seg_step(input int len, input bit inord);
      ifc.seg_val      = 1'b1;
      ifc.seg_len      = LEN_W'(len);
      ifc.seg_in_order = inord;
      step();
      clear_pulses();
   endtask

   task automatic sent_step();
      ifc.sent = 1'b1;
      step();
      clear_pulses();
   endtask

   task automatic wait_send(input int limit, output int waited);
      waited = 0;
      while (ifc.send !== 1'b1 && waited < limit) begin
         step();
         waited++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ifc.connected = 1'b1;
      ifc.loc_ack = 32'd0;
      ifc.win = '0;
      clear_pulses();
      repeat (3) step();
      n_tests++; if (ifc.send !== 1'b0) begin n_fail++; $display("FAIL reset_send: got %b expected 0", ifc.send); end
      n_tests++; if (ifc.reason !== 3'd0) begin n_fail++; $display("FAIL reset_reason: got %0d expected 0", ifc.reason); end
      n_tests++; if (ifc.ack_num !== 32'd0) begin n_fail++; $display("FAIL reset_ack_num: got %h expected 0", ifc.ack_num); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_timeout();
      int w;
      ifc.loc_ack = 32'h1000_0064;
      seg_step(100, 1'b1);
      n_tests++; if (ifc.send !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b expected 0", ifc.send); end
      wait_send(40, w);
      n_tests++; if (w != ACK_TIMEOUT) begin n_fail++; $display("FAIL tmo_latency: got %0d expected %0d", w, ACK_TIMEOUT); end
      n_tests++; if (ifc.reason !== 3'd0) begin n_fail++; $display("FAIL tmo_reason: got %0d expected 0", ifc.reason); end
      n_tests++; if (ifc.ack_num !== 32'h1000_0064) begin n_fail++; $display("FAIL tmo_ack_num: got %h expected 10000064", ifc.ack_num); end
      $display("[TB] timeout ack: reason=%0d ack_num=%h after %0d cycles", ifc.reason, ifc.ack_num, w);
      ifc.loc_ack = 32'h1000_0200;
      repeat (3) step();
      n_tests++; if (ifc.send !== 1'b1 || ifc.ack_num !== 32'h1000_0064) begin
         n_fail++; $display("FAIL tmo_hold: got send=%b ack=%h expected send=1 ack=10000064", ifc.send, ifc.ack_num);
      end
      sent_step();
      n_tests++; if (ifc.send !== 1'b0) begin n_fail++; $display("FAIL tmo_sent_clear: got %b expected 0", ifc.send); end
   endtask

   task automatic test_packets();
      int cnt;
      ifc.loc_ack = 32'h2000_0000;
      for (int i = 0; i < 5; i++) begin
         seg_step(100, 1'b1);
         if (i == 3) begin
            n_tests++; if (ifc.send !== 1'b0) begin n_fail++; $display("FAIL pkt_early: got %b expected 0", ifc.send); end
         end
      end
      n_tests++; if (ifc.send !== 1'b1) begin n_fail++; $display("FAIL pkt_send: got %b expected 1", ifc.send); end
      n_tests++; if (ifc.reason !== 3'd1) begin n_fail++; $display("FAIL pkt_reason: got %0d expected 1", ifc.reason); end
      $display("[TB] packet ack: reason=%0d ack_num=%h", ifc.reason, ifc.ack_num);
      sent_step();
      cnt = 0;
      repeat (30) begin
         step();
         if (ifc.send === 1'b1) cnt++;
      end
      n_tests++; if (cnt != 0) begin n_fail++; $display("FAIL pkt_idle_quiet: got %0d sends expected 0", cnt); end
   endtask

   task automatic test_bytes();
      seg_step(1460, 1'b1);
      n_tests++; if (ifc.send !== 1'b0) begin n_fail++; $display("FAIL byte_early: got %b expected 0", ifc.send); end
      seg_step(1460, 1'b1);
      n_tests++; if (ifc.send !== 1'b1) begin n_fail++; $display("FAIL byte_send: got %b expected 1", ifc.send); end
      n_tests++; if (ifc.reason !== 3'd2) begin n_fail++; $display("FAIL byte_reason: got %0d expected 2", ifc.reason); end
      $display("[TB] byte ack: reason=%0d", ifc.reason);
      sent_step();
   endtask

   task automatic test_dup();
      int nsend;
      nsend = 0;
      for (int i = 0; i < 5; i++) begin
         seg_step(200, 1'b0);
         if (ifc.send === 1'b1) begin
            nsend++;
            n_tests++; if (ifc.reason !== 3'd3) begin n_fail++; $display("FAIL dup_reason: got %0d expected 3", ifc.reason); end
            $display("[TB] dup ack %0d: reason=%0d", nsend, ifc.reason);
            sent_step();
         end else begin
            step();
         end
      end
      n_tests++; if (nsend != DUP_LIMIT) begin n_fail++; $display("FAIL dup_count: got %0d expected %0d", nsend, DUP_LIMIT); end
      seg_step(100, 1'b1);
      n_tests++; if (ifc.send !== 1'b0) begin n_fail++; $display("FAIL dup_inorder_quiet: got %b expected 0", ifc.send); end
      seg_step(100, 1'b0);
      n_tests++; if (ifc.send !== 1'b1 || ifc.reason !== 3'd3) begin
         n_fail++; $display("FAIL dup_rearm: got send=%b reason=%0d expected send=1 reason=3", ifc.send, ifc.reason);
      end
      sent_step();
   endtask

   task automatic test_sack_window();
      for (int i = 0; i < 4; i++) seg_step(100, 1'b1);
      n_tests++; if (ifc.send !== 1'b0) begin n_fail++; $display("FAIL sack_early: got %b expected 0", ifc.send); end
      ifc.sack_upd = 1'b1;
      seg_step(100, 1'b1);
      n_tests++; if (ifc.send !== 1'b1 || ifc.reason !== 3'd4) begin
         n_fail++; $display("FAIL sack_prio: got send=%b reason=%0d expected send=1 reason=4", ifc.send, ifc.reason);
      end
      $display("[TB] sack ack: reason=%0d", ifc.reason);
      sent_step();
      ifc.win = '0;
      ifc.init = 1'b1;
      step();
      clear_pulses();
      ifc.win = LEN_W'(2000);
      step();
      n_tests++; if (ifc.send !== 1'b1 || ifc.reason !== 3'd5) begin
         n_fail++; $display("FAIL win_update: got send=%b reason=%0d expected send=1 reason=5", ifc.send, ifc.reason);
      end
      $display("[TB] window ack: reason=%0d", ifc.reason);
      sent_step();
      step();
      n_tests++; if (ifc.send !== 1'b0) begin n_fail++; $display("FAIL win_rebase: got %b expected 0", ifc.send); end
   endtask

   task automatic test_reset_in_req();
      int cnt, w;
      ifc.loc_ack = 32'h3000_0000;
      ifc.sack_upd = 1'b1;
      step();
      clear_pulses();
      n_tests++; if (ifc.send !== 1'b1) begin n_fail++; $display("FAIL rreq_setup: got %b expected 1", ifc.send); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_tests++; if (ifc.send !== 1'b0 || ifc.reason !== 3'd0 || ifc.ack_num !== 32'd0) begin
         n_fail++; $display("FAIL rreq_clear: got send=%b reason=%0d ack=%h expected 0/0/0", ifc.send, ifc.reason, ifc.ack_num);
      end
      step();
      sent_step();
      cnt = 0;
      repeat (5) begin
         step();
         if (ifc.send === 1'b1) cnt++;
      end
      n_tests++; if (cnt != 0) begin n_fail++; $display("FAIL sent_in_idle: got %0d sends expected 0", cnt); end
      seg_step(100, 1'b1);
      wait_send(40, w);
      n_tests++; if (w != ACK_TIMEOUT || ifc.reason !== 3'd0) begin
         n_fail++; $display("FAIL rreq_counters: got latency=%0d reason=%0d expected %0d/0", w, ifc.reason, ACK_TIMEOUT);
      end
      sent_step();
   endtask

   task automatic test_random();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      for (int c = 0; c < 4000; c++) begin
         clear_pulses();
         rst              = ($urandom_range(0, 499) == 0);
         ifc.connected    = ($urandom_range(0, 399) != 0);
         ifc.init         = ($urandom_range(0, 299) == 0);
         ifc.loc_ack      = ifc.loc_ack + 32'($urandom_range(0, 3));
         ifc.seg_val      = ($urandom_range(0, 2) == 0);
         ifc.seg_in_order = ($urandom_range(0, 4) != 0);
         ifc.seg_len      = ($urandom_range(0, 3) == 0) ? '0 : LEN_W'($urandom_range(1, 1500));
         ifc.sack_upd     = ($urandom_range(0, 39) == 0);
         ifc.sent         = m_req ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 49) == 0) ifc.win = LEN_W'($urandom_range(0, 4000));
         step();
         n_tests++; if (ifc.send !== m_req) begin
            n_fail++; $display("FAIL rand_send cycle %0d: got %b expected %b", c, ifc.send, m_req);
         end
         n_tests++; if (ifc.reason !== 3'(m_reason)) begin
            n_fail++; $display("FAIL rand_reason cycle %0d: got %0d expected %0d", c, ifc.reason, m_reason);
         end
         n_tests++; if (ifc.ack_num !== m_ack) begin
            n_fail++; $display("FAIL rand_ack_num cycle %0d: got %h expected %h", c, ifc.ack_num, m_ack);
         end
      end
      rst = 1'b0;
      ifc.connected = 1'b1;
      clear_pulses();
   endtask

   initial begin
      ifc.connected = 1'b1;
      ifc.loc_ack   = 32'd0;
      ifc.win       = '0;
      clear_pulses();
      test_reset();
      test_timeout();
      test_packets();
      test_bytes();
      test_dup();
      test_sack_window();
      test_reset_in_req();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/tcp_vlg_ack_sched.md
Name: tcp_vlg_ack_sched

Overview:
- Next-generation pure-Ack scheduler for the TCP rx control path; generalises the fixed timeout/packet-count Ack generator.
- Decides when the tx engine must emit a payload-less Ack. Triggers:
  - delayed-Ack timeout
  - unacked packet count
  - unacked byte count
  - out-of-order arrival (immediate duplicate Ack)
  - SACK change
  - receive-window opening
- Sits between the rx segment path and the tx engine's send/sent handshake, one instance per connection.

Parameters:
- ACK_TIMEOUT, 20: clock ticks from first unacked segment to a forced Ack; must be ≥ 1.
- FORCE_ACK_PACKETS, 5: unacked in-order segments that force an Ack; 0 disables this trigger.
- FORCE_ACK_BYTES, 2920: unacked payload bytes that force an Ack; 0 disables this trigger.
- DUP_ACK_LIMIT, 3: maximum consecutive immediate duplicate Acks per out-of-order run.
- WIN_UPD_THRESH, 1460: window increase in bytes that forces a window-update Ack.
- LEN_W, 16: width of segment length and window fields.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- connected  in  1  connection established; while low, the block is held as in reset
- init  in  1  one-cycle pulse at connection open; clears all counters
- seg_val  in  1  one-cycle strobe per accepted received segment
- seg_len  in  LEN_W  payload length of the strobed segment
- seg_in_order  in  1  strobed segment's seq equals the current local Ack
- sack_upd  in  1  one-cycle pulse when any SACK block changes
- loc_ack  in  32  current local Ack number
- win  in  LEN_W  current local receive window
- send  out  1  request for a pure Ack
- reason  out  3  trigger code: 0 timeout, 1 packets, 2 bytes, 3 dup, 4 sack, 5 window
- ack_num  out  32  loc_ack latched at request time
- sent  in  1  one-cycle pulse from tx engine when the Ack leaves

Behaviour:
- Reset, init, or !connected:
  - state IDLE; send=0, reason=0, ack_num=0.
  - All counters cleared; last_win ← win.
- States: IDLE (nothing unacked), PEND (unacked data, timer running), REQ (send held high).
- Counters:
  - pkt_cnt 16 b and byte_cnt 32 b, both saturating.
  - timer: $clog2(ACK_TIMEOUT+1) bits.
  - dup_cnt: $clog2(DUP_ACK_LIMIT+1) bits.
- seg_val with seg_in_order=1 and seg_len>0:
  - pkt_cnt+1, byte_cnt+seg_len, dup_cnt←0.
  - IDLE→PEND, timer←0.
- seg_val with seg_in_order=0:
  - If dup_cnt<DUP_ACK_LIMIT: raise a dup trigger and increment dup_cnt.
  - Otherwise the segment is ignored.
- seg_len=0 with seg_in_order=1 (pure Ack from peer): no effect.
- PEND: timer increments each cycle; timer=ACK_TIMEOUT-1 raises the timeout trigger.
- Packet trigger: pkt_cnt reaches FORCE_ACK_PACKETS (non-zero).
- Byte trigger: byte_cnt ≥ FORCE_ACK_BYTES (non-zero); evaluated on the updated value in the same cycle.
- SACK trigger: sack_upd=1.
- Window trigger: win − last_win ≥ WIN_UPD_THRESH (unsigned, computed only when win > last_win).
- Triggers are evaluated every cycle in IDLE or PEND. Any trigger → REQ on the next edge:
  - send=1 (registered, one cycle after the causing input).
  - ack_num←loc_ack.
  - reason = highest-priority active trigger: dup > sack > bytes > packets > window > timeout.
- REQ:
  - send and ack_num are held stable until sent=1.
  - On sent: pkt_cnt, byte_cnt, timer cleared; last_win←win; go to IDLE.
  - Exception: if seg_val with an in-order payload arrives in the same cycle as sent, counters load that segment and the state goes to PEND.
- Triggers arising in REQ are absorbed; the Ack in flight covers them, since the tx engine samples the live loc_ack. A dup trigger in REQ still increments dup_cnt.
- sent outside REQ is ignored.
- Latency: trigger input edge → send high = 1 cycle. sent → next possible send = 1 cycle.

Test Plan:
- Single in-order 100-byte segment, no further input → send rises exactly ACK_TIMEOUT cycles after strobe (cycle 20), reason=0, ack_num=loc_ack.
- Five in-order 100-byte segments back-to-back → send one cycle after the 5th strobe, reason=1; sent clears counters; no further send for 30 idle cycles.
- Two 1460-byte segments → send after the 2nd strobe, reason=2 (bytes 2920), before the packet threshold.
- Five out-of-order segments, each answered by sent within 2 cycles → exactly 3 sends with reason=3; an in-order segment then re-arms dup_cnt.
- sack_upd pulse while state PEND and a 5th in-order strobe in the same cycle → reason=3? no: reason=4 (sack beats packets); win jump 0→2000 in IDLE → send, reason=5.
- rst asserted while send=1 → send=0 next cycle, counters zero; sent pulse while IDLE → no state change.
